ins_mem_responder: RTL and testbench

//  Responder end of the instruction-memory valid/ready handshake driven by PIPELINE_CONTROL
//  (pipeline_ins_mem_valid_out -> imem_valid_in, imem_ready_out -> pipeline_ins_mem_ready_in).

---
 rtl/ins_mem_if.sv | 34 +++
 rtl/ins_mem_responder.sv | 111 +++++++++++
 tb/tb_ins_mem_responder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ins_mem_if.sv
// Instruction-memory fetch interface between the pipeline (master) and the
// instruction-memory responder (slave), plus the preload write port.
//   imem_valid_in/imem_addr_in/imem_flush_in : fetch request and abort (master -> slave)
//   imem_ready_out/imem_data_out/imem_fault_out/imem_busy_out : response (slave -> master)
//   imem_load_en_in/imem_load_addr_in/imem_load_data_in : preload write (master -> slave)
interface ins_mem_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 256
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic            imem_valid_in;
    logic [XLEN-1:0] imem_addr_in;
    logic            imem_flush_in;
    logic            imem_ready_out;
    logic [XLEN-1:0] imem_data_out;
    logic            imem_fault_out;
    logic            imem_busy_out;
    logic            imem_load_en_in;
    logic [AW-1:0]   imem_load_addr_in;
    logic [XLEN-1:0] imem_load_data_in;

    modport master (
        output imem_valid_in, imem_addr_in, imem_flush_in,
        output imem_load_en_in, imem_load_addr_in, imem_load_data_in,
        input  imem_ready_out, imem_data_out, imem_fault_out, imem_busy_out
    );

    modport slave (
        input  imem_valid_in, imem_addr_in, imem_flush_in,
        input  imem_load_en_in, imem_load_addr_in, imem_load_data_in,
        output imem_ready_out, imem_data_out, imem_fault_out, imem_busy_out
    );
endinterface

// File: rtl/ins_mem_responder.sv
// Instruction-memory responder: accepts one fetch at a time on the valid/ready
// handshake, returns the addressed word after WAIT_STATES wait cycles, and
// supports abort (flush) while waiting. Misaligned or out-of-range fetches
// return NOP_WORD with fault set.
// Ports:
//   imem_clock_in : clock, rising edge
//   imem_reset_in : asynchronous reset, active low
//   bus           : ins_mem_if slave modport (request, response, preload)
// Timing: request accepted at edge t enters RESP at edge t+WAIT_STATES, so
// ready_out is high in the cycle after that edge and busy_out is high for
// WAIT_STATES+1 cycles; a held valid is re-accepted WAIT_STATES+2 edges later.
//
// state | meaning
// IDLE  | waiting for a request
// WAIT  | request accepted, counting wait states (flush aborts)
// RESP  | ready_out strobe cycle, response committed
module ins_mem_responder #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DEPTH       = 256,
    parameter int unsigned     WAIT_STATES = 2,
    parameter logic [XLEN-1:0] NOP_WORD    = 32'h0000_0013
) (
    input logic     imem_clock_in,
    input logic     imem_reset_in,
    ins_mem_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t          state, state_nxt;
    logic [3:0]      wait_cnt, wait_cnt_nxt;
    logic            accept;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] rd_addr;
    logic [XLEN-1:0] rd_word_idx;
    logic            rd_fault;
    logic [XLEN-1:0] mem [DEPTH];

    // With zero wait states RESP is entered on the accepting edge, so the
    // read must use the live address rather than the latched one.
    assign rd_addr     = (state == ST_IDLE) ? bus.imem_addr_in : addr_q;
    assign rd_word_idx = rd_addr >> 2;
    assign rd_fault    = (rd_addr[1:0] != 2'b00) || (rd_word_idx >= XLEN'(DEPTH));

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!bus.imem_flush_in && bus.imem_valid_in) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt = ST_RESP;
                    end else begin
                        wait_cnt_nxt = 4'(WAIT_STATES - 1);
                        state_nxt    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.imem_flush_in) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge imem_clock_in or negedge imem_reset_in) begin
        if (!imem_reset_in) begin
            state              <= ST_IDLE;
            wait_cnt           <= 4'd0;
            addr_q             <= '0;
            bus.imem_ready_out <= 1'b0;
            bus.imem_data_out  <= '0;
            bus.imem_fault_out <= 1'b0;
        end else begin
            state              <= state_nxt;
            wait_cnt           <= wait_cnt_nxt;
            bus.imem_ready_out <= (state_nxt == ST_RESP);
            if (accept) begin
                addr_q <= bus.imem_addr_in;
            end
            if (state_nxt == ST_RESP) begin
                if (rd_fault) begin
                    bus.imem_data_out  <= NOP_WORD;
                    bus.imem_fault_out <= 1'b1;
                end else begin
                    bus.imem_data_out  <= mem[rd_addr[AW+1:2]];
                    bus.imem_fault_out <= 1'b0;
                end
            end
        end
    end

    // Array is deliberately not reset; a same-edge write and read returns the old word.
    always_ff @(posedge imem_clock_in) begin
        if (bus.imem_load_en_in) begin
            mem[bus.imem_load_addr_in] <= bus.imem_load_data_in;
        end
    end

    assign bus.imem_busy_out = (state != ST_IDLE);
endmodule

// File: tb/tb_ins_mem_responder.sv
module tb_ins_mem_responder;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned W     = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ins_mem_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    ins_mem_responder #(
        .XLEN(XLEN), .DEPTH(DEPTH), .WAIT_STATES(W), .NOP_WORD(NOP)
    ) dut (
        .imem_clock_in(clk),
        .imem_reset_in(rst_n),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: timestamps of accept/response edges, not FSM states.
    logic [31:0] ref_mem [DEPTH];
    int          edge_no = 0;
    bit          inflight = 0;
    int          resp_edge = 0;
    int          free_edge = 0;
    logic [31:0] req_addr = '0;
    logic        exp_ready = 0, exp_fault = 0, exp_busy = 0;
    logic [31:0] exp_data = '0;

    int pulse_cnt = 0;
    int busy_cnt = 0;
    int obs_ready_edge = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_respond(input int e);
        inflight  = 0;
        free_edge = e + 2;
        exp_ready = 1;
        if (req_addr[1:0] != 2'b00 || (req_addr >> 2) >= DEPTH) begin
            exp_data  = NOP;
            exp_fault = 1;
        end else begin
            exp_data  = ref_mem[req_addr[9:2]];
            exp_fault = 0;
        end
    endtask

    task automatic model_clear();
        inflight  = 0;
        free_edge = edge_no;
        exp_ready = 0;
        exp_data  = '0;
        exp_fault = 0;
        exp_busy  = 0;
    endtask

    task automatic model_edge();
        exp_ready = 0;
        if (!rst_n) begin
            model_clear();
            free_edge = edge_no + 1;
        end else if (inflight) begin
            if (bus.imem_flush_in) begin
                inflight  = 0;
                free_edge = edge_no + 1;
            end else if (edge_no == resp_edge) begin
                model_respond(edge_no);
            end
        end else if (edge_no >= free_edge && !bus.imem_flush_in && bus.imem_valid_in) begin
            inflight  = 1;
            resp_edge = edge_no + W;
            req_addr  = bus.imem_addr_in;
            if (W == 0) model_respond(edge_no);
        end
        if (bus.imem_load_en_in) ref_mem[bus.imem_load_addr_in] = bus.imem_load_data_in;
        exp_busy = (inflight || exp_ready) && rst_n;
        edge_no++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("ready", {31'd0, bus.imem_ready_out}, {31'd0, exp_ready});
        check("data",  bus.imem_data_out, exp_data);
        check("fault", {31'd0, bus.imem_fault_out}, {31'd0, exp_fault});
        check("busy",  {31'd0, bus.imem_busy_out}, {31'd0, exp_busy});
        if (bus.imem_ready_out === 1'b1) begin
            pulse_cnt++;
            obs_ready_edge = edge_no - 1;
        end
        if (bus.imem_busy_out === 1'b1) busy_cnt++;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic f);
        bus.imem_valid_in = v;
        bus.imem_addr_in  = a;
        bus.imem_flush_in = f;
    endtask

    task automatic load(input logic en, input logic [7:0] idx, input logic [31:0] d);
        bus.imem_load_en_in   = en;
        bus.imem_load_addr_in = idx;
        bus.imem_load_data_in = d;
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check({tag, "_ready"}, {31'd0, bus.imem_ready_out}, 32'd0);
        check({tag, "_data"},  bus.imem_data_out, 32'd0);
        check({tag, "_fault"}, {31'd0, bus.imem_fault_out}, 32'd0);
        check({tag, "_busy"},  {31'd0, bus.imem_busy_out}, 32'd0);
    endtask

    initial begin
        int acc;
        int first_edge;
        int second_edge;
        logic [31:0] a;

        drive(1'b1, 32'h0, 1'b0);
        load(1'b0, 8'd0, 32'd0);

        // 1: reset held with valid high
        repeat (3) tick();
        #1;
        check("t1_ready", {31'd0, bus.imem_ready_out}, 32'd0);
        check("t1_data",  bus.imem_data_out, 32'd0);
        check("t1_busy",  {31'd0, bus.imem_busy_out}, 32'd0);
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // preload whole array with random words, then mem[4]
        for (int i = 0; i < DEPTH; i++) begin
            load(1'b1, 8'(i), $urandom);
            tick();
        end
        load(1'b1, 8'd4, 32'h0050_0093);
        tick();
        load(1'b0, 8'd0, 32'd0);

        // 2: single fetch @0x10
        busy_cnt = 0;
        acc = edge_no;
        drive(1'b1, 32'h10, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        repeat (6) tick();
        check("t2_latency", 32'(obs_ready_edge), 32'(acc + W));
        check("t2_data", bus.imem_data_out, 32'h0050_0093);
        check("t2_fault", {31'd0, bus.imem_fault_out}, 32'd0);
        check("t2_busy_cycles", 32'(busy_cnt), 32'(W + 1));

        // 3: valid held, addr 0x00 then 0x04
        pulse_cnt = 0;
        drive(1'b1, 32'h00, 1'b0);
        tick();
        drive(1'b1, 32'h04, 1'b0);
        first_edge = -1;
        second_edge = -1;
        for (int i = 0; i < 12 && second_edge < 0; i++) begin
            tick();
            if (bus.imem_ready_out === 1'b1) begin
                if (first_edge < 0) first_edge = obs_ready_edge;
                else second_edge = obs_ready_edge;
            end
            if (second_edge >= 0) check("t3_data1", bus.imem_data_out, ref_mem[1]);
        end
        drive(1'b0, 32'h0, 1'b0);
        check("t3_spacing", 32'(second_edge - first_edge), 32'(W + 2));
        repeat (4) tick();

        // 4: flush in first WAIT cycle
        pulse_cnt = 0;
        drive(1'b1, 32'h08, 1'b0);
        tick();
        drive(1'b0, 32'h08, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        repeat (5) tick();
        check("t4_no_ready", 32'(pulse_cnt), 32'd0);

        // 5: misaligned and out-of-range fetches
        foreach (a[i]) a[i] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? 32'h06 : 32'(DEPTH * 4);
            pulse_cnt = 0;
            drive(1'b1, a, 1'b0);
            tick();
            drive(1'b0, 32'h0, 1'b0);
            repeat (W + 2) tick();
            check("t5_pulse", 32'(pulse_cnt), 32'd1);
            check("t5_data", bus.imem_data_out, NOP);
            check("t5_fault", {31'd0, bus.imem_fault_out}, 32'd1);
        end

        // same-edge write/read of the fetched word returns the old word
        drive(1'b1, 32'h20, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        repeat (W - 1) tick();
        load(1'b1, 8'd8, 32'hCAFE_F00D);
        tick();
        load(1'b0, 8'd0, 32'd0);
        repeat (2) tick();
        drive(1'b1, 32'h20, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        repeat (W + 2) tick();
        check("wr_new_word", bus.imem_data_out, 32'hCAFE_F00D);

        // 6: reset mid-WAIT
        drive(1'b1, 32'h0C, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        async_reset_check("t6");
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        pulse_cnt = 0;
        repeat (6) tick();
        check("t6_no_ready", 32'(pulse_cnt), 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 85) a = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
            else a = $urandom;
            drive(1'($urandom_range(0, 99) < 60), a, 1'($urandom_range(0, 99) < 10));
            load(1'($urandom_range(0, 99) < 20), 8'($urandom_range(0, DEPTH - 1)), $urandom);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0);
        load(1'b0, 8'd0, 32'd0);
        repeat (W + 3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
